datapath_ctrl_fsm: RTL
======================

// Module: datapath_ctrl_fsm
// PURPOSE
//  Hardwired control sequencer for the Datapath. Fetches an instruction through PC/MAR/MDR into IR.
//  Decodes IR[31:27] (op), IR[26:23] (Ra), IR[22:19] (Rb), IR[18:15] (Rc).
//  Drives the per-step bus-out, register-enable and ALU opcode strobes that a bench otherwise drives by hand.
//  Sits beside Datapath; all outputs connect 1:1 to Datapath control ports.
// PARAMETERS
//  OP_W     5   width of opcode field / alu_op output
//  NREG     16  general registers; width of one-hot Rx_out / Rx_enable buses
// PORTS
//  clk          in   1     system clock, rising edge
//  clr          in   1     synchronous reset, active-low
//  run          in   1     1 = fetch next instr at T0; 0 = park in T0 (current instr completes)
//  mem_ready    in   1     memory data valid on Mdatain; sampled in T1
//  IR           in   32    IR register contents from Datapath
//  PC_out, ZLow_out, ZHigh_out, MDR_out              out 1  bus-source selects
//  MAR_enable, PC_enable, IncPC, MDR_enable, Read     out 1  fetch strobes
//  IR_enable, Y_enable, Z_enable, LO_enable, HI_enable out 1 latch strobes
//  R_out        out  NREG  one-hot register bus-out select
//  R_enable     out  NREG  one-hot register write enable
//  alu_op       out  OP_W  ALU opcode to Datapath
//  halted       out  1     1 while in HALT
//  illegal      out  1     1-cycle pulse in T3 when op is unsupported
// BEHAVIOUR
//  Reset: clk edge with clr==0 -> state RST; every output 0; clr wins over all inputs, mid-instruction too.
//  Outputs are Moore-decoded from state + IR; all outputs are 0 in any state not listed below.
//  RST -> T0 unconditionally.
//  T0: run=1 -> PC_out, MAR_enable, IncPC, PC_enable high; next T1. run=0 -> all outputs 0, stay in T0.
//  T1: Read, MDR_enable held high; mem_ready=0 -> stay in T1 (wait state, no limit); mem_ready=1 -> T2.
//  T2: MDR_out, IR_enable; next T3 (IR valid from T3 on).
//  T3 dispatch on IR[31:27]:
//    ALU 3-reg 00011..01011 (add,sub,and,or,ror,rol,shr,shra,shl): R_out[Rb], Y_enable; next T4.
//    mul 01111 / div 10000: R_out[Ra], Y_enable; next T4.
//    nop 11010: no strobes; next T0.
//    halt 11011: next HALT.
//    other: illegal=1, treated as nop; next T0.
//  T4: R_out[Rc] (3-reg) or R_out[Rb] (mul/div); alu_op=IR[31:27]; Z_enable; next T5.
//    alu_op is 0 outside T4.
//  T5: ZLow_out plus R_enable[Ra] (3-reg, then T0) or LO_enable (mul/div, then T6).
//  T6: ZHigh_out, HI_enable; next T0.
//  HALT: halted=1; all other outputs 0; exits only via clr.
//  Latency: 3-reg op = 6 clocks T0..T5 with mem_ready=1; mul/div = 7; nop = 4; +1 per T1 wait cycle.
//  Register index wrap: Ra/Rb/Rc are 4-bit and always in range; Ra==Rb==Rc is legal (same one-hot bit).
//  run falling mid-instruction has no effect until the next T0.
//  At most one bit of R_out and one bit of R_enable is high in any cycle.
// CONFIGURATION
//  INSTR_COUNT_EN defined: adds output instr_count [31:0].
//    instr_count is 0 on reset and increments by 1 on each exit from T5/T6, nop or illegal to T0.
//    It wraps 0xFFFFFFFF -> 0. HALT does not count.
//  INSTR_COUNT_EN undefined: no counter logic and no instr_count port.
// TESTING
//  1 clr=0 for 2 clks while in T4 -> next clk all outputs 0, state RST; then T0 after clr=1.
//  2 IR=0x30918000 (or R1,R2,R3), mem_ready=1 -> T3 R_out=0x0004; T4 R_out=0x0008, alu_op=5'b00110;
//    T5 R_enable=0x0002 with ZLow_out=1.
//  3 mem_ready=0 for 3 clks in T1 -> Read/MDR_enable high 4 cycles; IR_enable exactly 1 cycle after mem_ready=1.
//  4 IR=0x78900000 (mul R1,R2) -> T3 R_out=0x0002; T4 R_out=0x0004, alu_op=5'b01111;
//    T5 LO_enable=1; T6 HI_enable=1; then T0.
//  5 IR=0xD8000000 (halt) -> halted=1 from cycle after T3, outputs stay 0 for 20 clks; illegal op 0xF8000000 -> illegal pulse, back to T0.
//  6 INSTR_COUNT_EN: run 3 instrs (or, nop, mul) -> instr_count=3; run=0 -> PC_enable stays 0, count frozen.

Source files
------------

// File: rtl/datapath_ctrl_fsm.sv
// Hardwired fetch/decode/execute sequencer for the Datapath; optional INSTR_COUNT_EN adds instr_count.
// Latency: 3-reg op 6 clocks, mul/div 7, nop 4, plus one clock per T1 wait cycle.
// Backpressure: T1 holds Read until mem_ready; run=0 parks the sequencer in T0.
module datapath_ctrl_fsm #(
    parameter int OP_W = 5,
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            run,
    input  logic            mem_ready,
    input  logic [31:0]     IR,
    output logic            PC_out,
    output logic            ZLow_out,
    output logic            ZHigh_out,
    output logic            MDR_out,
    output logic            MAR_enable,
    output logic            PC_enable,
    output logic            IncPC,
    output logic            MDR_enable,
    output logic            Read,
    output logic            IR_enable,
    output logic            Y_enable,
    output logic            Z_enable,
    output logic            LO_enable,
    output logic            HI_enable,
    output logic [NREG-1:0] R_out,
    output logic [NREG-1:0] R_enable,
    output logic [OP_W-1:0] alu_op,
    output logic            halted,
    output logic            illegal
`ifdef INSTR_COUNT_EN
    ,
    output logic [31:0]     instr_count
`endif
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [4:0]      w_op;
    logic [3:0]      w_ra;
    logic [3:0]      w_rb;
    logic [3:0]      w_rc;
    logic [NREG-1:0] w_ra_oh;
    logic [NREG-1:0] w_rb_oh;
    logic [NREG-1:0] w_rc_oh;
    logic            w_alu3;
    logic            w_muldiv;
    logic            w_nop;
    logic            w_halt;
    logic            w_unused_ir;

    assign w_op        = IR[31:27];
    assign w_ra        = IR[26:23];
    assign w_rb        = IR[22:19];
    assign w_rc        = IR[18:15];
    assign w_unused_ir = ^IR[14:0];

    assign w_ra_oh = NREG'(1) << w_ra;
    assign w_rb_oh = NREG'(1) << w_rb;
    assign w_rc_oh = NREG'(1) << w_rc;

    assign w_alu3   = (w_op >= 5'd3) && (w_op <= 5'd11);
    assign w_muldiv = (w_op == 5'd15) || (w_op == 5'd16);
    assign w_nop    = (w_op == 5'd26);
    assign w_halt   = (w_op == 5'd27);

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        PC_out     = 1'b0;
        ZLow_out   = 1'b0;
        ZHigh_out  = 1'b0;
        MDR_out    = 1'b0;
        MAR_enable = 1'b0;
        PC_enable  = 1'b0;
        IncPC      = 1'b0;
        MDR_enable = 1'b0;
        Read       = 1'b0;
        IR_enable  = 1'b0;
        Y_enable   = 1'b0;
        Z_enable   = 1'b0;
        LO_enable  = 1'b0;
        HI_enable  = 1'b0;
        R_out      = '0;
        R_enable   = '0;
        alu_op     = '0;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_RST: w_next = S_T0;
            S_T0: begin
                if (run) begin
                    PC_out     = 1'b1;
                    MAR_enable = 1'b1;
                    IncPC      = 1'b1;
                    PC_enable  = 1'b1;
                    w_next     = S_T1;
                end
            end
            S_T1: begin
                Read       = 1'b1;
                MDR_enable = 1'b1;
                if (mem_ready) begin
                    w_next = S_T2;
                end
            end
            S_T2: begin
                MDR_out   = 1'b1;
                IR_enable = 1'b1;
                w_next    = S_T3;
            end
            S_T3: begin
                if (w_alu3) begin
                    R_out    = w_rb_oh;
                    Y_enable = 1'b1;
                    w_next   = S_T4;
                end else if (w_muldiv) begin
                    R_out    = w_ra_oh;
                    Y_enable = 1'b1;
                    w_next   = S_T4;
                end else if (w_halt) begin
                    w_next = S_HALT;
                end else begin
                    // Unsupported opcodes retire like a nop, flagged for one cycle.
                    illegal = !w_nop;
                    w_next  = S_T0;
                end
            end
            S_T4: begin
                R_out    = w_alu3 ? w_rc_oh : w_rb_oh;
                alu_op   = OP_W'(w_op);
                Z_enable = 1'b1;
                w_next   = S_T5;
            end
            S_T5: begin
                ZLow_out = 1'b1;
                if (w_muldiv) begin
                    LO_enable = 1'b1;
                    w_next    = S_T6;
                end else begin
                    R_enable = w_ra_oh;
                    w_next   = S_T0;
                end
            end
            S_T6: begin
                ZHigh_out = 1'b1;
                HI_enable = 1'b1;
                w_next    = S_T0;
            end
            S_HALT: halted = 1'b1;
            default: w_next = S_RST;
        endcase
    end

`ifdef INSTR_COUNT_EN
    logic        w_retire;
    logic [31:0] r_count;

    // Any return to T0 from an execute state retires one instruction.
    assign w_retire = (w_next == S_T0) &&
                      ((r_state == S_T3) || (r_state == S_T5) || (r_state == S_T6));

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign instr_count = r_count;
`endif

endmodule
